// File: rtl/read_stage_sb_if.sv
// read_stage_sb_if: decode->read->execute bus for read_stage_sb (handshakes, operands, writeback, flush).
// The stage uses the slave modport; the decode/execute/regfile side uses master.
interface read_stage_sb_if #(
    parameter int NUM_REGS  = 16,
    parameter int IDX_W     = 4,
    parameter int DATA_W    = 64,
    parameter int NUM_SRC   = 2,
    parameter int PAYLOAD_W = 512
);
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_SRC*IDX_W-1:0]    src_idx_in;
    logic [NUM_SRC-1:0]          src_valid_in;
    logic [IDX_W-1:0]            dest_idx_in;
    logic                        dest_valid_in;
    logic [PAYLOAD_W-1:0]        payload_in;
    logic [NUM_REGS*DATA_W-1:0]  regfile_in;
    logic                        wb_valid;
    logic [IDX_W-1:0]            wb_idx;
    logic [DATA_W-1:0]           wb_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_SRC*DATA_W-1:0]   operand_out;
    logic [NUM_SRC-1:0]          operand_valid_out;
    logic [IDX_W-1:0]            dest_idx_out;
    logic                        dest_valid_out;
    logic [PAYLOAD_W-1:0]        payload_out;

    modport master (
        output flush, in_valid, src_idx_in, src_valid_in, dest_idx_in, dest_valid_in, payload_in,
               regfile_in, wb_valid, wb_idx, wb_data, out_ready,
        input  in_ready, out_valid, operand_out, operand_valid_out, dest_idx_out, dest_valid_out,
               payload_out
    );

    modport slave (
        input  flush, in_valid, src_idx_in, src_valid_in, dest_idx_in, dest_valid_in, payload_in,
               regfile_in, wb_valid, wb_idx, wb_data, out_ready,
        output in_ready, out_valid, operand_out, operand_valid_out, dest_idx_out, dest_valid_out,
               payload_out
    );
endinterface

// File: rtl/read_stage_sb.sv
// read_stage_sb: registered register-read stage with busy scoreboard, hazard stalls and flush.
// Define READ_STAGE_FWD_EN to bypass same-cycle writeback data into source operands.
module read_stage_sb #(
    parameter int NUM_REGS  = 16,
    parameter int IDX_W     = 4,
    parameter int DATA_W    = 64,
    parameter int NUM_SRC   = 2,
    parameter int PAYLOAD_W = 512
) (
    input logic          clk,
    input logic          reset,
    read_stage_sb_if.slave bus
);
    logic [NUM_REGS-1:0]       busy;
    logic [NUM_REGS-1:0]       busyNext;
    logic [NUM_SRC-1:0]        srcHazard;
    logic [NUM_SRC*DATA_W-1:0] operandNext;
    logic                      destHazard;
    logic                      accept;
    logic                      outValid;
    logic [NUM_SRC*DATA_W-1:0] operandReg;
    logic [NUM_SRC-1:0]        operandValidReg;
    logic [IDX_W-1:0]          destIdxReg;
    logic                      destValidReg;
    logic [PAYLOAD_W-1:0]      payloadReg;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [IDX_W-1:0] idx;
        logic             fwd;
        logic [DATA_W-1:0] rfData;
        assign idx    = bus.src_idx_in[k*IDX_W +: IDX_W];
        assign rfData = bus.regfile_in[idx*DATA_W +: DATA_W];
`ifdef READ_STAGE_FWD_EN
        assign fwd = bus.wb_valid && bus.wb_idx == idx;
        assign operandNext[k*DATA_W +: DATA_W] =
            !bus.src_valid_in[k] ? '0 : fwd ? bus.wb_data : rfData;
`else
        assign fwd = 1'b0;
        assign operandNext[k*DATA_W +: DATA_W] = bus.src_valid_in[k] ? rfData : '0;
`endif
        assign srcHazard[k] = bus.src_valid_in[k] && busy[idx] && !fwd;
    end

    // A writeback to the destination clears busy at this edge, so WAW need not wait for it.
    assign destHazard = bus.dest_valid_in && busy[bus.dest_idx_in] &&
                        !(bus.wb_valid && bus.wb_idx == bus.dest_idx_in);
    assign bus.in_ready = !bus.flush && (!outValid || bus.out_ready) && !(|srcHazard) && !destHazard;
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        busyNext = busy;
        if (bus.wb_valid) busyNext[bus.wb_idx] = 1'b0;
        if (accept && bus.dest_valid_in) busyNext[bus.dest_idx_in] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy            <= '0;
            outValid        <= 1'b0;
            operandReg      <= '0;
            operandValidReg <= '0;
            destIdxReg      <= '0;
            destValidReg    <= 1'b0;
            payloadReg      <= '0;
        end else if (bus.flush) begin
            busy     <= '0;
            outValid <= 1'b0;
        end else begin
            busy <= busyNext;
            if (accept) begin
                outValid        <= 1'b1;
                operandReg      <= operandNext;
                operandValidReg <= bus.src_valid_in;
                destIdxReg      <= bus.dest_idx_in;
                destValidReg    <= bus.dest_valid_in;
                payloadReg      <= bus.payload_in;
            end else if (bus.out_ready) begin
                outValid <= 1'b0;
            end
        end
    end

    assign bus.out_valid         = outValid;
    assign bus.operand_out       = operandReg;
    assign bus.operand_valid_out = operandValidReg;
    assign bus.dest_idx_out      = destIdxReg;
    assign bus.dest_valid_out    = destValidReg;
    assign bus.payload_out       = payloadReg;
endmodule

// File: tb/tb_read_stage_sb.sv
// tb_read_stage_sb: vector table, directed corner sequences and random traffic for read_stage_sb,
// checked against a cycle-level reference model of the scoreboard and output slot.
module tb_read_stage_sb;
    localparam int NR = 16, IW = 4, DW = 64, NS = 2, PW = 512;
`ifdef READ_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    read_stage_sb_if #(.NUM_REGS(NR), .IDX_W(IW), .DATA_W(DW), .NUM_SRC(NS), .PAYLOAD_W(PW)) bus ();
    read_stage_sb #(.NUM_REGS(NR), .IDX_W(IW), .DATA_W(DW), .NUM_SRC(NS), .PAYLOAD_W(PW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rf [NR];
    always_comb for (int i = 0; i < NR; i++) bus.regfile_in[i*DW +: DW] = rf[i];

    // Reference model state
    logic [NR-1:0]    mBusy;
    logic             mValid;
    logic [NS*DW-1:0] mOps;
    logic [NS-1:0]    mOpV;
    logic [IW-1:0]    mDest;
    logic             mDestV;
    logic [PW-1:0]    mPay;

    function automatic void chk(string name, logic [PW-1:0] got, logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic logic [IW-1:0] srcIdx(int k);
        return bus.src_idx_in[k*IW +: IW];
    endfunction

    function automatic logic mFwd(logic [IW-1:0] r);
        return FWD && bus.wb_valid && bus.wb_idx == r;
    endfunction

    function automatic logic mReady();
        if (bus.flush || (mValid && !bus.out_ready)) return 1'b0;
        for (int k = 0; k < NS; k++)
            if (bus.src_valid_in[k] && mBusy[srcIdx(k)] && !mFwd(srcIdx(k))) return 1'b0;
        if (bus.dest_valid_in && mBusy[bus.dest_idx_in] && !(bus.wb_valid && bus.wb_idx == bus.dest_idx_in))
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic mReset();
        mBusy = '0; mValid = 0; mOps = '0; mOpV = '0; mDest = '0; mDestV = 0; mPay = '0;
    endtask

    task automatic mUpdate(logic acc);
        if (bus.flush) begin
            mValid = 0;
            mBusy = '0;
        end else begin
            if (acc) begin
                mValid = 1;
                for (int k = 0; k < NS; k++)
                    mOps[k*DW +: DW] = !bus.src_valid_in[k] ? '0 :
                                       mFwd(srcIdx(k)) ? bus.wb_data : rf[srcIdx(k)];
                mOpV = bus.src_valid_in; mDest = bus.dest_idx_in; mDestV = bus.dest_valid_in;
                mPay = bus.payload_in;
            end else if (bus.out_ready) begin
                mValid = 0;
            end
            if (bus.wb_valid) mBusy[bus.wb_idx] = 0;
            if (acc && bus.dest_valid_in) mBusy[bus.dest_idx_in] = 1;
        end
        if (bus.wb_valid) rf[bus.wb_idx] = bus.wb_data;
    endtask

    task automatic checkOuts();
        chk("out_valid", PW'(bus.out_valid), PW'(mValid));
        chk("operand_out", PW'(bus.operand_out), PW'(mOps));
        chk("operand_valid_out", PW'(bus.operand_valid_out), PW'(mOpV));
        chk("dest_idx_out", PW'(bus.dest_idx_out), PW'(mDest));
        chk("dest_valid_out", PW'(bus.dest_valid_out), PW'(mDestV));
        chk("payload_out", bus.payload_out, mPay);
        chk("busy", PW'(dut.busy), PW'(mBusy));
    endtask

    // Called just after a falling edge with inputs applied; returns after the next falling edge.
    task automatic step();
        logic expRdy;
        #1;
        expRdy = mReady();
        chk("in_ready", PW'(bus.in_ready), PW'(expRdy));
        @(posedge clk);
        #1;
        mUpdate(bus.in_valid && expRdy);
        @(negedge clk);
        checkOuts();
    endtask

    task automatic drive(logic iv, logic [IW-1:0] s0, logic [IW-1:0] s1, logic [NS-1:0] sv,
                         logic [IW-1:0] d, logic dv, logic [PW-1:0] pay);
        bus.in_valid = iv; bus.src_idx_in = {s1, s0}; bus.src_valid_in = sv;
        bus.dest_idx_in = d; bus.dest_valid_in = dv; bus.payload_in = pay;
    endtask

    typedef struct {
        logic [IW-1:0]    s0, s1;
        logic [NS-1:0]    sv;
        logic [IW-1:0]    d;
        logic             dv, wbv;
        logic [IW-1:0]    wbi;
        logic [DW-1:0]    wbd;
        logic             expRdy, expValid;
        logic [NS*DW-1:0] expOps;
    } vec_t;
    vec_t tbl [5];

    logic [PW-1:0]    snapPay;
    logic [NS*DW-1:0] snapOps;

    initial begin
        tbl[0] = '{4'd3, 4'd5, 2'b11, 4'd7, 1'b1, 1'b0, 4'd0, 64'h0, 1'b1, 1'b1, {64'h22, 64'h11}};
        tbl[1] = '{4'd7, 4'd0, 2'b01, 4'd8, 1'b0, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0, {64'h22, 64'h11}};
        tbl[2] = '{4'd7, 4'd0, 2'b01, 4'd8, 1'b0, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0, {64'h22, 64'h11}};
        tbl[3] = '{4'd7, 4'd0, 2'b01, 4'd8, 1'b0, 1'b1, 4'd7, 64'hABCD, FWD, FWD,
                   FWD ? {64'h0, 64'hABCD} : {64'h22, 64'h11}};
        tbl[4] = '{4'd7, 4'd0, 2'b01, 4'd8, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 1'b1, {64'h0, 64'hABCD}};

        for (int i = 0; i < NR; i++) rf[i] = 64'h1000 + 64'(i);
        rf[3] = 64'h11; rf[5] = 64'h22;
        bus.flush = 0; bus.out_ready = 1; bus.wb_valid = 0; bus.wb_idx = '0; bus.wb_data = '0;
        drive(0, 0, 0, 0, 0, 0, '0);
        mReset();
        @(negedge clk); @(negedge clk);
        checkOuts();
        reset = 0;

        for (int i = 0; i < 5; i++) begin
            drive(1, tbl[i].s0, tbl[i].s1, tbl[i].sv, tbl[i].d, tbl[i].dv, PW'(i + 1));
            bus.wb_valid = tbl[i].wbv; bus.wb_idx = tbl[i].wbi; bus.wb_data = tbl[i].wbd;
            #1 chk("tbl_ready", PW'(bus.in_ready), PW'(tbl[i].expRdy));
            step();
            chk("tbl_valid", PW'(bus.out_valid), PW'(tbl[i].expValid));
            chk("tbl_ops", PW'(bus.operand_out), PW'(tbl[i].expOps));
        end
        bus.wb_valid = 0;

        // Output stall: everything holds, then back-to-back transfers with no bubble
        bus.out_ready = 0;
        drive(1, 1, 2, 2'b11, 0, 0, PW'(32'hA1));
        snapPay = bus.payload_out; snapOps = bus.operand_out;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pay", bus.payload_out, snapPay);
            chk("stall_ops", PW'(bus.operand_out), PW'(snapOps));
        end
        bus.out_ready = 1;
        step();
        chk("b2b_first", bus.payload_out, PW'(32'hA1));
        drive(1, 3, 5, 2'b11, 0, 0, PW'(32'hA2));
        step();
        chk("b2b_valid", PW'(bus.out_valid), PW'(1'b1));
        chk("b2b_ops", PW'(bus.operand_out), PW'({64'h22, 64'h11}));

        // Writeback and accept hitting the same register: set wins
        drive(1, 0, 0, 2'b00, 2, 1, PW'(32'hB1));
        step();
        drive(1, 0, 0, 2'b00, 2, 1, PW'(32'hB2));
        bus.wb_valid = 1; bus.wb_idx = 2; bus.wb_data = 64'h77;
        #1 chk("waw_wb_ready", PW'(bus.in_ready), PW'(1'b1));
        step();
        chk("busy2_set", PW'(dut.busy[2]), PW'(1'b1));

        // Flush clears the slot and the scoreboard
        drive(1, 0, 0, 2'b00, 4, 1, PW'(32'hC1));
        step();
        bus.wb_valid = 0;
        drive(1, 0, 0, 2'b00, 9, 1, PW'(32'hC2));
        step();
        bus.flush = 1;
        drive(1, 4, 0, 2'b01, 0, 0, PW'(32'hC3));
        #1 chk("flush_ready", PW'(bus.in_ready), PW'(1'b0));
        step();
        bus.flush = 0;
        chk("flush_valid", PW'(bus.out_valid), PW'(1'b0));
        chk("flush_busy", PW'(dut.busy), PW'(0));
        #1 chk("post_flush_ready", PW'(bus.in_ready), PW'(1'b1));
        step();

        // Asynchronous reset in the middle of a stall
        drive(1, 0, 0, 2'b00, 6, 1, PW'(32'hD1));
        step();
        bus.out_ready = 0;
        drive(1, 6, 0, 2'b01, 0, 0, PW'(32'hD2));
        step();
        #2 reset = 1;
        mReset();
        #1;
        chk("arst_valid", PW'(bus.out_valid), PW'(1'b0));
        chk("arst_ops", PW'(bus.operand_out), PW'(0));
        chk("arst_pay", bus.payload_out, PW'(0));
        chk("arst_dest", PW'({bus.dest_idx_out, bus.dest_valid_out, bus.operand_valid_out}), PW'(0));
        @(negedge clk);
        reset = 0;
        bus.out_ready = 1;
        drive(1, 6, 6, 2'b11, 6, 1, PW'(32'hD3));
        #1 chk("arst_ready", PW'(bus.in_ready), PW'(1'b1));
        step();
        chk("dup_slots", PW'(bus.operand_out), PW'({rf[6], rf[6]}));

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, IW'($urandom_range(0, 5)), IW'($urandom_range(0, 5)),
                  NS'($urandom()), IW'($urandom_range(0, 5)), 1'($urandom()), '0);
            for (int j = 0; j < PW / 32; j++) bus.payload_in[j*32 +: 32] = $urandom();
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.wb_valid = $urandom_range(0, 4) < 2;
            bus.wb_idx = IW'($urandom_range(0, 5));
            bus.wb_data = {$urandom(), $urandom()};
            bus.flush = $urandom_range(0, 29) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
